// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the RV32I hazard/forwarding sequencer.
// The load/store encodings follow the decoder's info_load/info_store fields.
package hazard_ctrl_pkg;

  localparam logic [2:0] NOTLOAD = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  localparam logic [1:0] NOTSTORE = 2'd0;
  localparam logic [1:0] ST_SB    = 2'd1;
  localparam logic [1:0] ST_SH    = 2'd2;
  localparam logic [1:0] ST_SW    = 2'd3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // What the pipeline registers do at the next clock edge.
  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_HOLD     = 2'd1,
    ACT_REDIRECT = 2'd2,
    ACT_LOAD_USE = 2'd3
  } pipe_action_e;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       st;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       r2;
  } ex_entry_t;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       wr;
    logic       ld;
    logic       st;
  } mem_entry_t;

  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic       wr;
  } wb_entry_t;

  // x0 is hard-wired, so writes to it never produce a value worth tracking.
  function automatic logic is_producer(input logic v, input logic wr,
                                       input logic [4:0] dst);
    return v & wr & (dst != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one EX operand: the MEM producer is younger than WB,
// so it is checked first.
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic       ex_v,
  input  logic       use_src,
  input  logic [4:0] src,
  input  logic       mem_prod,
  input  logic [4:0] mem_dst,
  input  logic       wb_prod,
  input  logic [4:0] wb_dst,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_v && use_src) begin
      if (mem_prod && (mem_dst == src)) begin
        sel = FWD_MEM;
      end else if (wb_prod && (wb_dst == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stall/flush/bubble control,
// operand forwarding selects, memory-wait freeze and a retired counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_srcreg1_num,
  input  logic [4:0]       id_srcreg2_num,
  input  logic             id_reads_r2,
  input  logic [4:0]       id_dstreg_num,
  input  logic             id_write_reg,
  input  logic [2:0]       id_info_load,
  input  logic [1:0]       id_info_store,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] retire_cnt
);

  ex_entry_t    ex_q;
  mem_entry_t   mem_q;
  wb_entry_t    wb_q;
  ex_entry_t    id_entry;
  pipe_action_e action;

  logic mem_busy;
  logic ex_load_prod;
  logic load_use_hit;
  logic mem_prod;
  logic wb_prod;

  always_comb begin
    id_entry     = '0;
    id_entry.v   = id_valid;
    id_entry.dst = id_dstreg_num;
    id_entry.wr  = id_write_reg;
    id_entry.ld  = (id_info_load != NOTLOAD);
    id_entry.st  = (id_info_store != NOTSTORE);
    id_entry.rs1 = id_srcreg1_num;
    id_entry.rs2 = id_srcreg2_num;
    id_entry.r2  = id_reads_r2;
  end

  assign mem_busy     = mem_q.v & (mem_q.ld | mem_q.st) & ~dmem_ready;
  assign ex_load_prod = is_producer(ex_q.v, ex_q.wr, ex_q.dst) & ex_q.ld;
  assign load_use_hit = id_valid & ex_load_prod &
                        ((id_srcreg1_num == ex_q.dst) |
                         (id_reads_r2 & (id_srcreg2_num == ex_q.dst)));

  // A redirect kills the ID instruction, so its load-use hazard is moot.
  always_comb begin
    action = ACT_ADVANCE;
    if (mem_busy) begin
      action = ACT_HOLD;
    end else if (ex_redirect) begin
      action = ACT_REDIRECT;
    end else if (load_use_hit) begin
      action = ACT_LOAD_USE;
    end
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    freeze    = 1'b0;
    unique case (action)
      ACT_HOLD: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        freeze   = 1'b1;
      end
      ACT_REDIRECT: begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      ACT_LOAD_USE: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_prod = is_producer(mem_q.v, mem_q.wr, mem_q.dst);
  assign wb_prod  = is_producer(wb_q.v, wb_q.wr, wb_q.dst);

  hazard_fwd_unit u_fwd_a (
    .ex_v     (ex_q.v),
    .use_src  (1'b1),
    .src      (ex_q.rs1),
    .mem_prod (mem_prod),
    .mem_dst  (mem_q.dst),
    .wb_prod  (wb_prod),
    .wb_dst   (wb_q.dst),
    .sel      (fwd_a_sel)
  );

  hazard_fwd_unit u_fwd_b (
    .ex_v     (ex_q.v),
    .use_src  (ex_q.r2),
    .src      (ex_q.rs2),
    .mem_prod (mem_prod),
    .mem_dst  (mem_q.dst),
    .wb_prod  (wb_prod),
    .wb_dst   (wb_q.dst),
    .sel      (fwd_b_sel)
  );

  // Every non-frozen cycle shifts the pipe; killed slots enter EX as empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      retire_cnt <= '0;
    end else if (action != ACT_HOLD) begin
      wb_q.v     <= mem_q.v;
      wb_q.dst   <= mem_q.dst;
      wb_q.wr    <= mem_q.wr;
      mem_q.v    <= ex_q.v;
      mem_q.dst  <= ex_q.dst;
      mem_q.wr   <= ex_q.wr;
      mem_q.ld   <= ex_q.ld;
      mem_q.st   <= ex_q.st;
      ex_q       <= (action == ACT_ADVANCE) ? id_entry : '0;
      if (wb_q.v) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// random instruction streams, all compared against a stage-list reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_srcreg1_num;
  logic [4:0]       id_srcreg2_num;
  logic             id_reads_r2;
  logic [4:0]       id_dstreg_num;
  logic             id_write_reg;
  logic [2:0]       id_info_load;
  logic [1:0]       id_info_store;
  logic             ex_redirect;
  logic             dmem_ready;
  logic             stall_if;
  logic             stall_id;
  logic             flush_id;
  logic             bubble_ex;
  logic             freeze;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] retire_cnt;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_srcreg1_num (id_srcreg1_num),
    .id_srcreg2_num (id_srcreg2_num),
    .id_reads_r2    (id_reads_r2),
    .id_dstreg_num  (id_dstreg_num),
    .id_write_reg   (id_write_reg),
    .id_info_load   (id_info_load),
    .id_info_store  (id_info_store),
    .ex_redirect    (ex_redirect),
    .dmem_ready     (dmem_ready),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .flush_id       (flush_id),
    .bubble_ex      (bubble_ex),
    .freeze         (freeze),
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel),
    .retire_cnt     (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       live;
    bit [4:0] rd;
    bit       wr;
    bit [2:0] ld_code;
    bit [1:0] st_code;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       r2;
  } instr_t;

  // Reference pipe: index 0 = EX, 1 = MEM, 2 = WB.
  instr_t      pipe_m[3];
  int unsigned retired_m;
  int          n_checks = 0;
  int          n_fails  = 0;

  logic       obs_stall_if, obs_stall_id, obs_flush_id, obs_bubble_ex, obs_freeze;
  logic [1:0] obs_fwd_a, obs_fwd_b;
  logic [CNT_W-1:0] obs_retire;

  function automatic instr_t mk(input bit live, input int rd, input bit wr,
                                input int ldc, input int stc, input int rs1,
                                input int rs2, input bit r2);
    instr_t i;
    i.live = live; i.rd = 5'(rd); i.wr = wr; i.ld_code = 3'(ldc);
    i.st_code = 2'(stc); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.r2 = r2;
    return i;
  endfunction

  function automatic bit producer(input instr_t s);
    return s.live && s.wr && (s.rd != 0);
  endfunction

  function automatic logic [1:0] expect_fwd(input bit en, input bit [4:0] src);
    if (!pipe_m[0].live || !en) return 2'd0;
    if (producer(pipe_m[1]) && pipe_m[1].rd == src) return 2'd1;
    if (producer(pipe_m[2]) && pipe_m[2].rd == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one ID-stage cycle, checks the combinational outputs, then steps the model.
  task automatic applyStimulus(input instr_t ins, input bit redir,
                               input bit ready, input bit do_rst);
    bit     exp_freeze, exp_redir, exp_lu;
    instr_t ex;
    rst            = do_rst;
    id_valid       = ins.live;
    id_srcreg1_num = ins.rs1;
    id_srcreg2_num = ins.rs2;
    id_reads_r2    = ins.r2;
    id_dstreg_num  = ins.rd;
    id_write_reg   = ins.wr;
    id_info_load   = ins.ld_code;
    id_info_store  = ins.st_code;
    ex_redirect    = redir;
    dmem_ready     = ready;
    #3;
    ex         = pipe_m[0];
    exp_freeze = pipe_m[1].live && (pipe_m[1].ld_code != NOTLOAD ||
                 pipe_m[1].st_code != NOTSTORE) && !ready;
    exp_redir  = !exp_freeze && redir;
    exp_lu     = !exp_freeze && !exp_redir && ins.live && producer(ex) &&
                 ex.ld_code != NOTLOAD &&
                 (ins.rs1 == ex.rd || (ins.r2 && ins.rs2 == ex.rd));
    obs_stall_if = stall_if;   obs_stall_id = stall_id; obs_flush_id = flush_id;
    obs_bubble_ex = bubble_ex; obs_freeze = freeze;
    obs_fwd_a = fwd_a_sel;     obs_fwd_b = fwd_b_sel;   obs_retire = retire_cnt;
    if (!do_rst) begin
      checkOutput("freeze",    freeze,     exp_freeze);
      checkOutput("stall_if",  stall_if,   exp_freeze || exp_lu);
      checkOutput("stall_id",  stall_id,   exp_freeze || exp_lu);
      checkOutput("flush_id",  flush_id,   exp_redir);
      checkOutput("bubble_ex", bubble_ex,  exp_redir || exp_lu);
      checkOutput("fwd_a",     fwd_a_sel,  expect_fwd(1'b1, ex.rs1));
      checkOutput("fwd_b",     fwd_b_sel,  expect_fwd(ex.r2, ex.rs2));
      checkOutput("retire",    retire_cnt, retired_m);
    end
    @(posedge clk);
    if (do_rst) begin
      for (int s = 0; s < 3; s++) pipe_m[s].live = 1'b0;
      retired_m = 0;
    end else if (!exp_freeze) begin
      if (pipe_m[2].live) retired_m = (retired_m + 1) % (1 << CNT_W);
      pipe_m[2] = pipe_m[1];
      pipe_m[1] = pipe_m[0];
      pipe_m[0] = (exp_redir || exp_lu) ? mk(0, 0, 0, 0, 0, 0, 0, 0) : ins;
    end
    #1;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.live = ($urandom_range(0, 9) != 0);
    i.rd   = 5'($urandom_range(0, 3));
    i.wr   = 1'($urandom_range(0, 1));
    i.ld_code = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 5)) : NOTLOAD;
    i.st_code = (i.ld_code == NOTLOAD && $urandom_range(0, 4) == 0) ?
                2'($urandom_range(1, 3)) : NOTSTORE;
    i.rs1  = 5'($urandom_range(0, 3));
    i.rs2  = 5'($urandom_range(0, 3));
    i.r2   = 1'($urandom_range(0, 1));
    return i;
  endfunction

  instr_t nop_i, lw_i, add_i, addi_i, sub_i, sw_i, addi0_i, addx0_i, live_i;

  initial begin
    nop_i   = mk(0, 0, 0, 0, 0, 0, 0, 0);
    lw_i    = mk(1, 13, 1, LD_LW, NOTSTORE, 10, 0, 0);
    add_i   = mk(1, 12, 1, NOTLOAD, NOTSTORE, 13, 11, 1);
    addi_i  = mk(1, 11, 1, NOTLOAD, NOTSTORE, 10, 0, 0);
    sub_i   = mk(1, 12, 1, NOTLOAD, NOTSTORE, 12, 11, 1);
    sw_i    = mk(1, 0, 0, NOTLOAD, ST_SW, 10, 11, 1);
    addi0_i = mk(1, 0, 1, NOTLOAD, NOTSTORE, 0, 0, 0);
    addx0_i = mk(1, 1, 1, NOTLOAD, NOTSTORE, 0, 0, 1);
    live_i  = mk(1, 0, 0, NOTLOAD, NOTSTORE, 0, 0, 0);
    for (int s = 0; s < 3; s++) pipe_m[s] = nop_i;
    retired_m = 0;

    applyStimulus(nop_i, 0, 1, 1);
    applyStimulus(nop_i, 0, 1, 1);
    applyStimulus(nop_i, 0, 1, 0);
    checkOutput("reset_retire", obs_retire, 0);
    checkOutput("reset_stall",  obs_stall_if, 0);

    // Load-use: LW x13 in EX with ADD x12,x13,x11 in ID.
    applyStimulus(lw_i, 0, 1, 0);
    applyStimulus(add_i, 0, 1, 0);
    checkOutput("lu_stall_if", obs_stall_if, 1);
    checkOutput("lu_bubble",   obs_bubble_ex, 1);
    applyStimulus(add_i, 0, 1, 0);
    checkOutput("lu_one_cycle", obs_stall_if, 0);
    applyStimulus(nop_i, 0, 1, 0);

    // ALU-to-ALU forwarding, back-to-back and with one NOP between.
    applyStimulus(addi_i, 0, 1, 0);
    applyStimulus(sub_i, 0, 1, 0);
    checkOutput("alu_no_stall", obs_stall_if, 0);
    applyStimulus(nop_i, 0, 1, 0);
    checkOutput("alu_fwd_mem", obs_fwd_b, 1);
    applyStimulus(addi_i, 0, 1, 0);
    applyStimulus(nop_i, 0, 1, 0);
    applyStimulus(sub_i, 0, 1, 0);
    applyStimulus(nop_i, 0, 1, 0);
    checkOutput("alu_fwd_wb", obs_fwd_b, 2);

    // Redirect in the same cycle as a load-use hazard.
    applyStimulus(lw_i, 0, 1, 0);
    applyStimulus(add_i, 1, 1, 0);
    checkOutput("rd_flush",  obs_flush_id, 1);
    checkOutput("rd_bubble", obs_bubble_ex, 1);
    checkOutput("rd_stall",  obs_stall_if, 0);
    applyStimulus(nop_i, 0, 1, 0);
    checkOutput("rd_ex_empty_a", obs_fwd_a, 0);
    applyStimulus(nop_i, 0, 1, 0);
    applyStimulus(nop_i, 0, 1, 0);

    // Store waiting three cycles on data memory.
    applyStimulus(sw_i, 0, 1, 0);
    applyStimulus(nop_i, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(nop_i, 0, 0, 0);
      checkOutput("mw_freeze", obs_freeze, 1);
    end
    applyStimulus(nop_i, 0, 1, 0);
    checkOutput("mw_release", obs_freeze, 0);

    // x0 destination never forwards or stalls.
    applyStimulus(addi0_i, 0, 1, 0);
    applyStimulus(addx0_i, 0, 1, 0);
    checkOutput("x0_no_stall", obs_stall_if, 0);
    applyStimulus(nop_i, 0, 1, 0);
    checkOutput("x0_fwd_a", obs_fwd_a, 0);
    checkOutput("x0_fwd_b", obs_fwd_b, 0);

    // Reset while frozen, then counter wrap after 16 retirements.
    applyStimulus(sw_i, 0, 1, 0);
    applyStimulus(nop_i, 0, 1, 0);
    applyStimulus(nop_i, 0, 0, 0);
    checkOutput("rf_frozen", obs_freeze, 1);
    applyStimulus(nop_i, 0, 0, 1);
    applyStimulus(nop_i, 0, 0, 0);
    checkOutput("rf_freeze", obs_freeze, 0);
    checkOutput("rf_stall",  obs_stall_if, 0);
    checkOutput("rf_retire", obs_retire, 0);
    for (int k = 0; k < 16; k++) applyStimulus(live_i, 0, 1, 0);
    for (int k = 0; k < 3; k++) applyStimulus(nop_i, 0, 1, 0);
    checkOutput("wrap_cnt", retire_cnt, 0);

    for (int k = 0; k < 800; k++) begin
      applyStimulus(rand_instr(), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
